// File: rtl/div_32by16.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient
// bit per clock, with start/done handshake, busy and divide-by-zero flags.
module div_32by16 #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] ain,
  input  logic [DW-1:0]   bin,
  output logic [2*DW-1:0] quot,
  output logic [DW-1:0]   rem,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);

  localparam int CW = $clog2(2*DW) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(2*DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [2*DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]     dvs_q, dvs_d;
  logic [DW:0]       r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*DW-1:0]   quot_q, quot_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic              div_zero_q, div_zero_d;

  logic [DW:0]       r_shift;
  logic [DW:0]       r_sub;
  logic [DW:0]       r_new;
  logic              q_bit;
  logic [2*DW-1:0]   dvd_new;

  // One restoring step; quotient bits fill the dividend register from the LSB end.
  always_comb begin
    r_shift = {r_q[DW-1:0], dvd_q[2*DW-1]};
    r_sub   = r_shift - {1'b0, dvs_q};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_new   = q_bit ? r_sub : r_shift;
    dvd_new = {dvd_q[2*DW-2:0], q_bit};
  end

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bin == '0) begin
            quot_d     = '1;
            rem_d      = ain[DW-1:0];
            div_zero_d = 1'b1;
            state_d    = FIN;
          end else begin
            dvd_d      = ain;
            dvs_d      = bin;
            r_d        = '0;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_new;
        r_d   = r_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          quot_d  = dvd_new;
          rem_d   = r_new[DW-1:0];
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q == CALC);
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_div_32by16.sv
// Directed self-checking bench for div_32by16: hand-computed quotients/remainders,
// handshake timing, divide-by-zero, ignored start and mid-operation reset.
module tb_div_32by16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ain = '0;
  logic [15:0] bin = '0;
  logic [31:0] quot;
  logic [15:0] rem;
  logic        busy, done, div_zero;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] last_q = '0;

  always #5 clk = ~clk;

  div_32by16 #(.DW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ain      (ain),
    .bin      (bin),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one operation and follow it to its done pulse (bounded wait).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er, input int ebusy);
    int  busy_cnt;
    int  done_at;
    bit  overlap;
    @(negedge clk);
    ain = a; bin = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0; done_at = -1; overlap = 1'b0;
    for (int cyc = 1; cyc <= 100 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_dz0"}, 32'(div_zero), 32'(b == 16'd0));
        if (b != 16'd0) chk({tag, "_qhold"}, quot, last_q);
      end
      if (busy && done) overlap = 1'b1;
      if (busy) busy_cnt++;
      if (done) done_at = cyc;
    end
    chk({tag, "_doneat"}, 32'(done_at), 32'(ebusy + 1));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(ebusy));
    chk({tag, "_ovl"}, 32'(overlap), 32'd0);
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_dz"}, 32'(div_zero), 32'(b == 16'd0));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    last_q = eq;
  endtask

  initial begin
    int done_cnt;
    int first_done;

    // Reset state
    #12;
    chk("rst_quot", quot, 32'd0);
    chk("rst_flags", {28'd0, busy, done, div_zero, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("basic", 32'd100, 16'd7, 32'd14, 16'd2, 32);
    run_div("maxmax", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 32);
    run_div("maxone", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 32);
    run_div("small", 32'd5, 16'd9, 32'd0, 16'd5, 32);
    run_div("zerodvd", 32'd0, 16'd3, 32'd0, 16'd0, 32);
    run_div("divz", 32'h1234_5678, 16'd0, 32'hFFFF_FFFF, 16'h5678, 0);
    run_div("afterdz", 32'd77, 16'd10, 32'd7, 16'd7, 32);

    // A second start during CALC must be ignored
    @(negedge clk);
    ain = 32'd1000; bin = 16'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; first_done = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (cyc == 10) begin ain = 32'd7; bin = 16'd1; start = 1'b1; end
      if (cyc == 11) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
    end
    chk("ign_ndone", 32'(done_cnt), 32'd1);
    chk("ign_doneat", 32'(first_done), 32'd33);
    chk("ign_quot", quot, 32'd100);
    chk("ign_rem", 32'(rem), 32'd0);
    last_q = 32'd100;

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    ain = 32'd1000; bin = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_quot", quot, 32'd0);
    chk("mrst_rem", 32'(rem), 32'd0);
    chk("mrst_flags", {28'd0, busy, done, div_zero, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("mrst_idle", 32'(done_cnt), 32'd0);
    last_q = 32'd0;
    run_div("postrst", 32'd50000, 16'd300, 32'd166, 16'd200, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
